// File: rtl/stream_pkg.sv
// Shared stream definitions: arbiter state type and width/keep helpers used by
// the stream masters, slaves and arbiters.
package stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    ABORT = 2'd2,
    DRAIN = 2'd3
  } arb_state_e;

  // Widest keep vector the helpers accept (512-bit data)
  localparam int unsigned KEEP_MAX_W = 64;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  // Index of the last valid byte of an LSB-contiguous keep; 0 for an empty keep
  function automatic int unsigned keep2vldb(input logic [KEEP_MAX_W-1:0] keep);
    int unsigned n;
    n = 0;
    for (int i = 0; i < KEEP_MAX_W; i++) n += 32'(keep[i]);
    return (n == 0) ? 0 : n - 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requester at or after ptr, wrapping, as a one-hot grant.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt
);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = PTR_W'((32'(ptr) + 32'(i)) % NUM_REQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_pkt_arbiter.sv
// Packet-granular round-robin mux of NUM_SRC stream masters onto one registered
// sink, with a mid-packet stall watchdog that aborts and drains silent sources.
module stream_pkt_arbiter
  import stream_pkg::*;
#(
  parameter  int unsigned NUM_SRC   = 4,
  parameter  int unsigned DATA_W    = 64,
  parameter  int unsigned STALL_TO  = 1024,
  localparam int unsigned DATA_BE_W = DATA_W / 8,
  localparam int unsigned VLDB_W    = (clog2(DATA_BE_W - 1) > 0) ? clog2(DATA_BE_W - 1) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [NUM_SRC-1:0]            s_axis_valid_i,
  input  logic [NUM_SRC*DATA_W-1:0]     s_axis_data_i,
  input  logic [NUM_SRC*DATA_BE_W-1:0]  s_axis_keep_i,
  input  logic [NUM_SRC-1:0]            s_axis_sop_i,
  input  logic [NUM_SRC-1:0]            s_axis_eop_i,
  input  logic [NUM_SRC-1:0]            s_axis_err_i,
  output logic [NUM_SRC-1:0]            s_axis_ready_o,
  output logic                          m_axis_valid_o,
  output logic [DATA_W-1:0]             m_axis_data_o,
  output logic [DATA_BE_W-1:0]          m_axis_keep_o,
  output logic [VLDB_W-1:0]             m_axis_vldb_o,
  output logic                          m_axis_sop_o,
  output logic                          m_axis_eop_o,
  output logic                          m_axis_err_o,
  input  logic                          m_axis_ready_i,
  output logic [NUM_SRC-1:0]            grant_o,
  output logic [15:0]                   abort_cnt_o,
  output logic                          proto_err_o
);

  localparam int unsigned IDX_W     = clog2(NUM_SRC);
  localparam int unsigned WD_W      = (clog2(STALL_TO + 1) > 0) ? clog2(STALL_TO + 1) : 1;
  localparam int unsigned STALL_LIM = (STALL_TO > 0) ? STALL_TO - 1 : 0;

  arb_state_e           state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q;
  logic [IDX_W-1:0]     gidx, next_ptr;
  logic [WD_W-1:0]      wd_cnt_q;
  logic                 first_q;
  logic [NUM_SRC-1:0]   arb_gnt;
  logic                 adv, acc, wd_hit;
  logic                 sel_valid, sel_sop, sel_eop, sel_err;
  logic [DATA_W-1:0]    sel_data;
  logic [DATA_BE_W-1:0] sel_keep;

  rr_arbiter #(
    .NUM_REQ (NUM_SRC),
    .PTR_W   (IDX_W)
  ) u_rr (
    .req (s_axis_valid_i),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt)
  );

  // Mux of the granted source's beat
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    sel_keep  = '0;
    sel_sop   = 1'b0;
    sel_eop   = 1'b0;
    sel_err   = 1'b0;
    gidx      = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (grant_o[k]) begin
        sel_valid = s_axis_valid_i[k];
        sel_data  = s_axis_data_i[k*DATA_W +: DATA_W];
        sel_keep  = s_axis_keep_i[k*DATA_BE_W +: DATA_BE_W];
        sel_sop   = s_axis_sop_i[k];
        sel_eop   = s_axis_eop_i[k];
        sel_err   = s_axis_err_i[k];
        gidx      = IDX_W'(k);
      end
    end
  end

  assign adv      = !m_axis_valid_o || m_axis_ready_i;
  assign acc      = (state_q == XFER) && adv && sel_valid;
  assign next_ptr = (gidx == IDX_W'(NUM_SRC - 1)) ? '0 : gidx + IDX_W'(1);
  // Only source-side silence counts; a held beat under backpressure never does
  assign wd_hit   = (STALL_TO != 0) && (state_q == XFER) && !sel_valid &&
                    (wd_cnt_q == WD_W'(STALL_LIM));
  assign m_axis_vldb_o = VLDB_W'(keep2vldb(KEEP_MAX_W'(m_axis_keep_o)));

  always_comb begin
    state_d        = state_q;
    s_axis_ready_o = '0;
    case (state_q)
      IDLE:  if (|s_axis_valid_i) state_d = XFER;
      XFER: begin
        s_axis_ready_o = adv ? grant_o : '0;
        if (acc && sel_eop) state_d = IDLE;
        else if (wd_hit)    state_d = ABORT;
      end
      ABORT: if (adv) state_d = DRAIN;
      DRAIN: begin
        s_axis_ready_o = grant_o;
        if (sel_valid && sel_eop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      m_axis_valid_o <= 1'b0;
      m_axis_data_o  <= '0;
      m_axis_keep_o  <= '0;
      m_axis_sop_o   <= 1'b0;
      m_axis_eop_o   <= 1'b0;
      m_axis_err_o   <= 1'b0;
      grant_o        <= '0;
      abort_cnt_o    <= '0;
      proto_err_o    <= 1'b0;
      rr_ptr_q       <= '0;
      wd_cnt_q       <= '0;
      first_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (adv) m_axis_valid_o <= 1'b0;
          if (|s_axis_valid_i) begin
            grant_o <= arb_gnt;
            first_q <= 1'b1;
          end
          wd_cnt_q <= '0;
        end
        XFER: begin
          if (acc) begin
            m_axis_valid_o <= 1'b1;
            m_axis_data_o  <= sel_data;
            m_axis_keep_o  <= sel_keep;
            m_axis_sop_o   <= sel_sop || first_q;
            m_axis_eop_o   <= sel_eop;
            m_axis_err_o   <= sel_err;
            if (first_q && !sel_sop) proto_err_o <= 1'b1;
            first_q  <= 1'b0;
            wd_cnt_q <= '0;
            if (sel_eop) begin
              rr_ptr_q <= next_ptr;
              grant_o  <= '0;
            end
          end else begin
            if (adv) m_axis_valid_o <= 1'b0;
            if (!sel_valid) wd_cnt_q <= wd_cnt_q + WD_W'(1);
          end
        end
        ABORT: begin
          // Synthetic terminator so the sink sees a closed, errored packet
          if (adv) begin
            m_axis_valid_o <= 1'b1;
            m_axis_data_o  <= '0;
            m_axis_keep_o  <= DATA_BE_W'(1);
            m_axis_sop_o   <= 1'b0;
            m_axis_eop_o   <= 1'b1;
            m_axis_err_o   <= 1'b1;
            if (abort_cnt_o != 16'hFFFF) abort_cnt_o <= abort_cnt_o + 16'd1;
          end
        end
        DRAIN: begin
          if (adv) m_axis_valid_o <= 1'b0;
          if (sel_valid && sel_eop) begin
            rr_ptr_q <= next_ptr;
            grant_o  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
